cache_fill_fsm: RTL and testbench

- Initiator side of the word-wide, byte-addressed data memory interface.
- On a cache miss, issues one read per word of the missing block to the pipelined memory.
- Collects the in-order data responses and streams them into the cache data array, then pulses the tag-array write.
- Sits between the I/D cache control logic and the multi-cycle memory. The memory is the responder.

---
 rtl/cache_fill_fsm.sv | 120 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Block-fill initiator: issues one word read per block word to a pipelined memory and
// streams the in-order responses into the cache data array. Optional: CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_detected,
  input  logic [ADDR_WIDTH-1:0]  miss_address,
  output logic                   fsm_busy,
  output logic                   mem_enable,
  output logic                   mem_wr,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic                   mem_data_valid,
  input  logic [15:0]            mem_data,
  output logic                   write_data_array,
  output logic [OFFSET_BITS-1:0] word_offset,
  output logic [15:0]            write_data,
  output logic                   write_tag_array,
  output logic                   fill_done
);

  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int CW    = OFFSET_BITS + 1;
  localparam int HI    = ADDR_WIDTH - OFFSET_BITS - 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state;
  logic [HI-1:0]          base_hi;
  logic [OFFSET_BITS-1:0] start;
  logic [CW-1:0]          req_cnt;
  logic [CW-1:0]          rsp_cnt;

  logic [OFFSET_BITS-1:0] miss_start;
  logic [OFFSET_BITS-1:0] req_idx;
  logic [OFFSET_BITS-1:0] rsp_idx;
  logic                   start_fill;
  logic                   req_open;
  logic                   last_rsp;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_address[OFFSET_BITS:1];
`else
  assign miss_start = '0;
`endif

  // Indices are OFFSET_BITS wide so the sum wraps inside the block; no carry reaches the tag.
  assign req_idx    = start + req_cnt[OFFSET_BITS-1:0];
  assign rsp_idx    = start + rsp_cnt[OFFSET_BITS-1:0];
  assign start_fill = (state == IDLE) && miss_detected;
  assign req_open   = req_cnt < CW'(WORDS);
  assign last_rsp   = (state == FILL) && mem_data_valid && (rsp_cnt == CW'(WORDS - 1));
  assign mem_wr     = 1'b0;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    mem_address      = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    write_data       = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    if (start_fill) begin
      // First request leaves in the miss cycle itself, straight from the incoming address.
      fsm_busy    = 1'b1;
      mem_enable  = 1'b1;
      mem_address = {miss_address[ADDR_WIDTH-1:OFFSET_BITS+1], miss_start, 1'b0};
    end else if (state == FILL) begin
      fsm_busy = 1'b1;
      if (req_open) begin
        mem_enable  = 1'b1;
        mem_address = {base_hi, req_idx, 1'b0};
      end
      if (mem_data_valid) begin
        write_data_array = 1'b1;
        word_offset      = rsp_idx;
        write_data       = mem_data;
      end
      write_tag_array = last_rsp;
      fill_done       = last_rsp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base_hi <= '0;
      start   <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state   <= FILL;
            base_hi <= miss_address[ADDR_WIDTH-1:OFFSET_BITS+1];
            start   <= miss_start;
            req_cnt <= CW'(1);
            rsp_cnt <= '0;
          end
        end
        FILL: begin
          if (req_open)       req_cnt <= req_cnt + 1'b1;
          if (mem_data_valid) rsp_cnt <= rsp_cnt + 1'b1;
          if (last_rsp) begin
            state   <= IDLE;
            req_cnt <= '0;
            rsp_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: table of fill scenarios driven against a
// latency-configurable memory model with a response scoreboard, plus reset/idle sequences.
module tb_cache_fill_fsm;

  localparam int AW    = 16;
  localparam int OB    = 3;
  localparam int WORDS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          fsm_busy;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_address;
  logic          mem_data_valid;
  logic [15:0]   mem_data;
  logic          write_data_array;
  logic [OB-1:0] word_offset;
  logic [15:0]   write_data;
  logic          write_tag_array;
  logic          fill_done;

  cache_fill_fsm #(.ADDR_WIDTH(AW), .OFFSET_BITS(OB)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_address      (mem_address),
    .mem_data_valid   (mem_data_valid),
    .mem_data         (mem_data),
    .write_data_array (write_data_array),
    .word_offset      (word_offset),
    .write_data       (write_data),
    .write_tag_array  (write_tag_array),
    .fill_done        (fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    int          lat;
    int          drop_after;
    bit          keep_miss;
    logic [15:0] exp_first;
    int          exp_done;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int start_of(input logic [15:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(a[3:1]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [15:0] exp_addr(input logic [15:0] a, input int k);
    logic [2:0] idx;
    idx = 3'((start_of(a) + k) % WORDS);
    return {a[15:4], idx, 1'b0};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check(name, {fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array, fill_done,
                 word_offset, mem_address, write_data}, 64'd0);
  endtask

  // Runs one complete fill; called right after a posedge. Returns aligned after the next posedge.
  task automatic run_fill(input vec_t v);
    rsp_t        memq[$];
    logic [15:0] exp_data[$];
    int          exp_off[$];
    rsp_t        r;
    int          cyc, req_k, drv_k, rsp_k, done_cyc;
    cyc = 0; req_k = 0; drv_k = 0; rsp_k = 0; done_cyc = -1;
    miss_detected  = 1'b1;
    miss_address   = v.addr;
    mem_data_valid = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      if (memq.size() > 0 && memq[0].due == cyc) begin
        r = memq.pop_front();
        mem_data_valid = 1'b1;
        mem_data       = r.data;
        exp_data.push_back(r.data);
        exp_off.push_back((start_of(v.addr) + drv_k) % WORDS);
        drv_k++;
      end else begin
        mem_data_valid = 1'b0;
        mem_data       = 16'($urandom);
      end
      if (cyc == v.drop_after) miss_detected = 1'b0;
      @(negedge clk);
      check("busy", fsm_busy, 1'b1);
      check("mem_wr", mem_wr, 1'b0);
      check("tag_eq_done", write_tag_array, fill_done);
      if (cyc == 0) check("first_addr", mem_address, v.exp_first);
      if (mem_enable) begin
        check("req_addr", mem_address, exp_addr(v.addr, req_k));
        req_k++;
        memq.push_back('{data: 16'($urandom), due: cyc + v.lat});
      end
      check("wr_en", write_data_array, mem_data_valid);
      if (write_data_array && exp_off.size() > 0) begin
        check("wr_off", word_offset, exp_off.pop_front());
        check("wr_data", write_data, exp_data.pop_front());
        rsp_k++;
      end
      if (fill_done) begin
        check("done_rsps", rsp_k, WORDS);
        done_cyc = cyc;
      end
      next_cycle();
      cyc++;
    end
    if (done_cyc < 0) check("done_timeout", 0, 1);
    check("done_cycle", done_cyc, v.exp_done);
    check("req_count", req_k, WORDS);
    mem_data_valid = 1'b0;
    if (!v.keep_miss) miss_detected = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t v;
    vecs[0] = '{addr: 16'h1236, lat: 4, drop_after: 999, keep_miss: 1'b0, exp_first: 16'h1230, exp_done: 11};
    vecs[1] = '{addr: 16'h0A10, lat: 1, drop_after: 999, keep_miss: 1'b0, exp_first: 16'h0A10, exp_done: 8};
    vecs[2] = '{addr: 16'h2220, lat: 3, drop_after: 2,   keep_miss: 1'b0, exp_first: 16'h2220, exp_done: 10};
    vecs[3] = '{addr: 16'hFFFC, lat: 2, drop_after: 999, keep_miss: 1'b1, exp_first: 16'hFFF0, exp_done: 9};
    vecs[4] = '{addr: 16'h00F2, lat: 1, drop_after: 999, keep_miss: 1'b0, exp_first: 16'h00F0, exp_done: 8};
`ifdef CRITICAL_WORD_FIRST_EN
    vecs[0].exp_first = 16'h1236;
    vecs[3].exp_first = 16'hFFFC;
    vecs[4].exp_first = 16'h00F2;
`endif

    rst            = 1'b1;
    miss_detected  = 1'b0;
    miss_address   = 16'h0000;
    mem_data_valid = 1'b0;
    mem_data       = 16'h0000;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_idle("reset_outs");
    next_cycle();
    rst = 1'b0;

    // Entry 3 keeps miss high so entry 4 exercises a back-to-back fill.
    for (int i = 0; i < 5; i++) begin
      run_fill(vecs[i]);
      if (!vecs[i].keep_miss) begin
        @(negedge clk);
        check_idle("post_fill_idle");
        next_cycle();
      end
    end

    // Reset three cycles into a fill, then stale responses must be dropped.
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    @(negedge clk);
    check("rst_seq_req0", mem_enable, 1'b1);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst           = 1'b0;
    miss_detected = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hBEEF;
      @(negedge clk);
      check_idle("stale_rsp_idle");
      next_cycle();
    end
    mem_data_valid = 1'b0;
    v = '{addr: 16'h4000, lat: 2, drop_after: 999, keep_miss: 1'b0, exp_first: 16'h4000, exp_done: 9};
    run_fill(v);
    @(negedge clk);
    check_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
